// File: rtl/wt_dcache_rd_arb_if.sv
// Read-port bundle between the dcache requesters, the arbiter and the cache memory.
// The arbiter side uses the slave modport.
interface wt_dcache_rd_arb_if #(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned IdxWidth = 8,
    parameter int unsigned OffWidth = 4,
    parameter int unsigned TagWidth = 20
);
    logic [NumPorts-1:0]               rd_req;
    logic [NumPorts-1:0]               rd_tag_only;
    logic [NumPorts-1:0][IdxWidth-1:0] rd_idx;
    logic [NumPorts-1:0][OffWidth-1:0] rd_off;
    logic [NumPorts-1:0][TagWidth-1:0] rd_tag;
    logic [NumPorts-1:0]               rd_ack;
    logic [NumPorts-1:0]               rd_vld;
    logic                              mem_rd_req;
    logic                              mem_rd_tag_only;
    logic [IdxWidth-1:0]               mem_rd_idx;
    logic [OffWidth-1:0]               mem_rd_off;
    logic [TagWidth-1:0]               mem_rd_tag;
    logic                              mem_rd_ack;

    modport master (
        output rd_req, rd_tag_only, rd_idx, rd_off, rd_tag, mem_rd_ack,
        input  rd_ack, rd_vld, mem_rd_req, mem_rd_tag_only,
        input  mem_rd_idx, mem_rd_off, mem_rd_tag
    );

    modport slave (
        input  rd_req, rd_tag_only, rd_idx, rd_off, rd_tag, mem_rd_ack,
        output rd_ack, rd_vld, mem_rd_req, mem_rd_tag_only,
        output mem_rd_idx, mem_rd_off, mem_rd_tag
    );
endinterface

// File: rtl/wt_dcache_rd_arb.sv
// Round-robin arbiter for the shared L1 dcache read port.
// Index/offset go out in the request cycle, the tag one cycle after the ack.
package config_pkg;
    typedef struct packed {
        logic [31:0] xlen;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

package wt_cache_pkg;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_TAG_WIDTH    = 20;
endpackage

module wt_dcache_rd_arb #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NumPorts      = 3,
    parameter int unsigned StallCntWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    wt_dcache_rd_arb_if.slave        bus,
    output logic [StallCntWidth-1:0] stall_cnt_o
);
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PW-1:0]            ptr_q;
    logic                     lock_q;
    logic [PW-1:0]            lock_id_q;
    logic                     ack_vld_q;
    logic [PW-1:0]            ack_id_q;
    logic [StallCntWidth-1:0] stall_cnt_q;

    logic [PW-1:0] win;
    logic [PW-1:0] win_nxt;
    logic          any_req;
    logic          ack;
    logic          found;

    assign any_req = |bus.rd_req;
    assign ack     = bus.mem_rd_ack & any_req;

    // First requester at or after the pointer; a live lock overrides it.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            int unsigned j;
            j = int'(ptr_q) + i;
            if (j >= NumPorts) j = j - NumPorts;
            if (!found && bus.rd_req[j]) begin
                win   = PW'(j);
                found = 1'b1;
            end
        end
        if (lock_q && bus.rd_req[lock_id_q]) begin
            win = lock_id_q;
        end
    end

    assign win_nxt = (32'(win) == NumPorts - 1) ? '0 : win + 1'b1;

    always_comb begin
        bus.rd_ack = '0;
        if (ack) bus.rd_ack[win] = 1'b1;
    end

    always_comb begin
        bus.rd_vld = '0;
        if (ack_vld_q) bus.rd_vld[ack_id_q] = 1'b1;
    end

    assign bus.mem_rd_req      = any_req;
    assign bus.mem_rd_tag_only = any_req & bus.rd_tag_only[win];
    assign bus.mem_rd_idx      = any_req ? bus.rd_idx[win] : '0;
    assign bus.mem_rd_off      = any_req ? bus.rd_off[win] : '0;

    // Late tag belongs to last cycle's winner; otherwise feed the current one.
    always_comb begin
        bus.mem_rd_tag = '0;
        if (ack_vld_q) begin
            bus.mem_rd_tag = bus.rd_tag[ack_id_q];
        end else if (any_req) begin
            bus.mem_rd_tag = bus.rd_tag[win];
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            ack_vld_q   <= 1'b0;
            ack_id_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ack_vld_q <= ack;
            if (ack) begin
                ptr_q    <= win_nxt;
                ack_id_q <= win;
                lock_q   <= 1'b0;
            end else if (any_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= win;
            end else begin
                lock_q <= 1'b0;
            end
            if (any_req && !bus.mem_rd_ack) begin
                if (!(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            end else begin
                stall_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed bench for wt_dcache_rd_arb: rotation, lock, stall counter,
// reset during tag phase and tag-only requests.
module tb_wt_dcache_rd_arb;
    import wt_cache_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned IW = DCACHE_CL_IDX_WIDTH;
    localparam int unsigned OW = DCACHE_OFFSET_WIDTH;
    localparam int unsigned TW = DCACHE_TAG_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] stall;
    logic [1:0] stall2;
    int n_chk = 0;
    int n_fail = 0;

    logic [TW-1:0] tg [3] = '{20'hA0000, 20'hA0001, 20'hA0002};
    logic [IW-1:0] ix [3] = '{8'h10, 8'h11, 8'h12};

    always #5 clk = ~clk;

    wt_dcache_rd_arb_if #(.NumPorts(N), .IdxWidth(IW),
        .OffWidth(OW), .TagWidth(TW)) b ();
    wt_dcache_rd_arb_if #(.NumPorts(N), .IdxWidth(IW),
        .OffWidth(OW), .TagWidth(TW)) b2 ();

    wt_dcache_rd_arb #(.NumPorts(N), .StallCntWidth(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(b), .stall_cnt_o(stall));

    wt_dcache_rd_arb #(.NumPorts(N), .StallCntWidth(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b2), .stall_cnt_o(stall2));

    task automatic cyc(input logic [2:0] req, input logic ack);
        @(negedge clk);
        b.rd_req = req;
        b.mem_rd_ack = ack;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        b.rd_req = '0;
        b.rd_tag_only = '0;
        b.mem_rd_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        b.rd_req = '0;
        b.mem_rd_ack = 1'b1;
        #1;
        n_chk++;
        if (b.rd_ack !== 3'b000) begin
            n_fail++; $display("FAIL reset_ack got %b want 000", b.rd_ack);
        end
        n_chk++;
        if (b.rd_vld !== 3'b000) begin
            n_fail++; $display("FAIL reset_vld got %b want 000", b.rd_vld);
        end
        n_chk++;
        if ({b.mem_rd_req, b.mem_rd_idx, b.mem_rd_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_fwd got %b/%h/%h want 0", b.mem_rd_req,
                b.mem_rd_idx, b.mem_rd_tag);
        end
        n_chk++;
        if (stall !== 8'd0) begin
            n_fail++; $display("FAIL reset_stall got %0d want 0", stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b.mem_rd_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] ea, ev;
        logic [TW-1:0] et;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(3'b111, 1'b1);
            ea = 3'b001 << (k % 3);
            ev = (k == 0) ? 3'b000 : 3'b001 << ((k - 1) % 3);
            et = (k == 0) ? tg[0] : tg[(k - 1) % 3];
            n_chk++;
            if (b.rd_ack !== ea) begin
                n_fail++; $display("FAIL rr_ack[%0d] got %b want %b", k, b.rd_ack, ea);
            end
            n_chk++;
            if (b.rd_vld !== ev) begin
                n_fail++; $display("FAIL rr_vld[%0d] got %b want %b", k, b.rd_vld, ev);
            end
            n_chk++;
            if (b.mem_rd_tag !== et) begin
                n_fail++; $display("FAIL rr_tag[%0d] got %h want %h", k, b.mem_rd_tag, et);
            end
            n_chk++;
            if (b.mem_rd_idx !== ix[k % 3]) begin
                n_fail++;
                $display("FAIL rr_idx[%0d] got %h want %h", k, b.mem_rd_idx, ix[k % 3]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            cyc(3'b101, 1'b0);
            n_chk++;
            if (b.rd_ack !== 3'b000 || b.mem_rd_idx !== ix[0] ||
                stall !== 8'(c)) begin
                n_fail++;
                $display("FAIL stall[%0d] got ack %b idx %h cnt %0d want 000 %h %0d",
                    c, b.rd_ack, b.mem_rd_idx, stall, ix[0], c);
            end
        end
        cyc(3'b101, 1'b1);
        n_chk++;
        if (b.rd_ack !== 3'b001 || stall !== 8'd5) begin
            n_fail++;
            $display("FAIL stall_ack0 got %b cnt %0d want 001 5", b.rd_ack, stall);
        end
        cyc(3'b101, 1'b1);
        n_chk++;
        if (b.rd_ack !== 3'b100 || stall !== 8'd0) begin
            n_fail++;
            $display("FAIL stall_ack2 got %b cnt %0d want 100 0", b.rd_ack, stall);
        end
    endtask

    task automatic test_lock_drop();
        do_reset();
        cyc(3'b010, 1'b0);
        cyc(3'b011, 1'b0);
        n_chk++;
        if (b.mem_rd_idx !== ix[1]) begin
            n_fail++; $display("FAIL lock_hold got %h want %h", b.mem_rd_idx, ix[1]);
        end
        cyc(3'b100, 1'b0);
        n_chk++;
        if (b.mem_rd_idx !== ix[2] || b.rd_ack !== 3'b000) begin
            n_fail++;
            $display("FAIL lock_drop got %h/%b want %h/000", b.mem_rd_idx, b.rd_ack, ix[2]);
        end
        cyc(3'b100, 1'b1);
        n_chk++;
        if (b.rd_ack !== 3'b100) begin
            n_fail++; $display("FAIL lock_switch got %b want 100", b.rd_ack);
        end
        cyc(3'b000, 1'b0);
        n_chk++;
        if (b.rd_vld !== 3'b100 || b.mem_rd_tag !== tg[2]) begin
            n_fail++;
            $display("FAIL lock_vld got %b/%h want 100/%h", b.rd_vld, b.mem_rd_tag, tg[2]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            b2.rd_req = 3'b001;
            b2.mem_rd_ack = 1'b0;
            #1;
            if (c == 2 || c == 6) begin
                n_chk++;
                if (stall2 !== ((c == 2) ? 2'd2 : 2'd3)) begin
                    n_fail++; $display("FAIL sat[%0d] got %0d", c, stall2);
                end
            end
        end
        @(negedge clk);
        b2.rd_req = 3'b000;
        @(negedge clk);
        #1;
        n_chk++;
        if (stall2 !== 2'd0) begin
            n_fail++; $display("FAIL sat_clear got %0d want 0", stall2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(3'b100, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        b.rd_req = '0;
        #1;
        n_chk++;
        if (b.rd_vld !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_vld2 got %b want 000", b.rd_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b010, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        b.rd_req = '0;
        #1;
        n_chk++;
        if (b.rd_vld !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_vld1 got %b want 000", b.rd_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b111, 1'b1);
        n_chk++;
        if (b.rd_ack !== 3'b001) begin
            n_fail++; $display("FAIL rst_mid_ptr got %b want 001", b.rd_ack);
        end
    endtask

    task automatic test_tag_only();
        do_reset();
        @(negedge clk);
        b.rd_tag_only = 3'b010;
        b.rd_req = 3'b010;
        b.mem_rd_ack = 1'b1;
        #1;
        n_chk++;
        if (b.mem_rd_tag_only !== 1'b1 || b.rd_ack !== 3'b010) begin
            n_fail++;
            $display("FAIL tag_only got %b/%b want 1/010", b.mem_rd_tag_only, b.rd_ack);
        end
        @(negedge clk);
        b.rd_req = '0;
        b.rd_tag_only = '0;
        b.mem_rd_ack = 1'b0;
        #1;
        n_chk++;
        if (b.rd_vld !== 3'b010 || b.mem_rd_tag_only !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_only_vld got %b/%b want 010/0", b.rd_vld, b.mem_rd_tag_only);
        end
    endtask

    initial begin
        b.rd_req = '0;
        b.rd_tag_only = '0;
        b.mem_rd_ack = 1'b0;
        b2.rd_req = '0;
        b2.rd_tag_only = '0;
        b2.mem_rd_ack = 1'b0;
        b2.rd_idx = '0;
        b2.rd_off = '0;
        b2.rd_tag = '0;
        for (int i = 0; i < 3; i++) begin
            b.rd_idx[i] = ix[i];
            b.rd_off[i] = OW'(i + 1);
            b.rd_tag[i] = tg[i];
        end
        test_reset();
        test_round_robin();
        test_stall();
        test_lock_drop();
        test_saturate();
        test_reset_mid();
        test_tag_only();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
